// File: rtl/mpp_prog_mem_if.sv
// Fetch and load bus between the mpp core (master) and its program memory (slave).
interface mpp_prog_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  // Fetch: a falling edge on cs_n with addr stable requests one word; rvalid pulses
  // once with rdata. Load: a load_en cycle either writes or is answered by load_err.
  logic              cs_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              oob_err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;

  modport master (
    output cs_n, addr, load_en, load_addr, load_data,
    input  rdata, rvalid, busy, oob_err, load_err
  );

  modport slave (
    input  cs_n, addr, load_en, load_addr, load_data,
    output rdata, rvalid, busy, oob_err, load_err
  );
endinterface

// File: rtl/mpp_prog_mem.sv
// Clocked program memory for the mpp core: edge-triggered fetch with programmable
// wait states, out-of-range fill word, and a run-time load port.
module mpp_prog_mem #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 32,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE  = '0
) (
  input  logic              clk,
  input  logic              rst,
  mpp_prog_mem_if.slave     bus,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t              state;
  state_t              state_n;
  logic                cs_n_q;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                oob_q;
  logic                load_err_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic start;
  logic fetch_in_range;
  logic load_in_range;
  logic load_ok;
  logic load_rej;

  // Full-width compare with one extra bit so DEPTH == 2**ADDR_W is representable.
  assign fetch_in_range = {1'b0, addr_q} < DEPTH_L;
  assign load_in_range  = {1'b0, bus.load_addr} < DEPTH_L;

  assign start    = (state == S_IDLE) && !bus.cs_n && cs_n_q;
  assign load_ok  = bus.load_en && !rst && (state == S_IDLE) && !start && load_in_range;
  assign load_rej = bus.load_en && !load_ok;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = (WAIT_STATES > 0) ? S_WAIT : S_READ;
      S_WAIT: begin
        if (bus.cs_n)            state_n = S_IDLE;
        else if (cnt == CNT_LAST) state_n = S_READ;
      end
      S_READ:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cs_n_q     <= 1'b1;
      cnt        <= 4'd0;
      addr_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      oob_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state      <= state_n;
      cs_n_q     <= bus.cs_n;
      rvalid_q   <= 1'b0;
      oob_q      <= 1'b0;
      load_err_q <= load_rej;
      if (start) begin
        addr_q <= bus.addr;
        cnt    <= 4'd0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (state == S_READ) begin
        rdata_q  <= fetch_in_range ? mem[addr_q[IDX_W-1:0]] : FILL_VALUE;
        rvalid_q <= 1'b1;
        oob_q    <= !fetch_in_range;
      end
    end
  end

  // Program image survives reset; only the load port writes it.
  always_ff @(posedge clk) begin
    if (load_ok) mem[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.oob_err  = oob_q;
  assign bus.load_err = load_err_q;
  assign bus.busy     = (state != S_IDLE) || rvalid_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mpp_prog_mem.sv
// Bench for mpp_prog_mem: three instances (1, 0 and 4 wait states) share one stimulus
// bus gated by sel and are checked against an array model of the program image.
module tb_mpp_prog_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic [15:0] addr;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  int          sel;

  always #5 clk = ~clk;

  mpp_prog_mem_if #(.DATA_W(8), .ADDR_W(16)) bus0 ();
  mpp_prog_mem_if #(.DATA_W(8), .ADDR_W(16)) bus1 ();
  mpp_prog_mem_if #(.DATA_W(8), .ADDR_W(16)) bus2 ();
  logic [1:0] st0, st1, st2;

  assign bus0.cs_n = (sel == 0) ? cs_n : 1'b1;
  assign bus1.cs_n = (sel == 1) ? cs_n : 1'b1;
  assign bus2.cs_n = (sel == 2) ? cs_n : 1'b1;
  assign bus0.load_en = (sel == 0) && load_en;
  assign bus1.load_en = (sel == 1) && load_en;
  assign bus2.load_en = (sel == 2) && load_en;
  assign bus0.addr = addr;       assign bus1.addr = addr;       assign bus2.addr = addr;
  assign bus0.load_addr = load_addr; assign bus1.load_addr = load_addr; assign bus2.load_addr = load_addr;
  assign bus0.load_data = load_data; assign bus1.load_data = load_data; assign bus2.load_data = load_data;

  mpp_prog_mem #(.DATA_W(8), .ADDR_W(16), .DEPTH(32), .WAIT_STATES(1), .FILL_VALUE(8'h00))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(st0));
  mpp_prog_mem #(.DATA_W(8), .ADDR_W(16), .DEPTH(32), .WAIT_STATES(0), .FILL_VALUE(8'h00))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1));
  mpp_prog_mem #(.DATA_W(8), .ADDR_W(16), .DEPTH(32), .WAIT_STATES(4), .FILL_VALUE(8'h00))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(st2));

  logic [7:0] rd_o;
  logic       rv_o, busy_o, oob_o, lerr_o;
  logic [1:0] st_o;

  always_comb begin
    rd_o = bus0.rdata; rv_o = bus0.rvalid; busy_o = bus0.busy;
    oob_o = bus0.oob_err; lerr_o = bus0.load_err; st_o = st0;
    case (sel)
      1: begin
        rd_o = bus1.rdata; rv_o = bus1.rvalid; busy_o = bus1.busy;
        oob_o = bus1.oob_err; lerr_o = bus1.load_err; st_o = st1;
      end
      2: begin
        rd_o = bus2.rdata; rv_o = bus2.rvalid; busy_o = bus2.busy;
        oob_o = bus2.oob_err; lerr_o = bus2.load_err; st_o = st2;
      end
      default: ;
    endcase
  end

  // Reference: program image per instance, plus wait states per instance.
  logic [7:0] mem_m [3][32];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic int ws_of(input int s);
    case (s)
      0:       return 1;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input int s, input logic [15:0] a);
    if (a < 16'd32) return mem_m[s][a[4:0]];
    return 8'h00;
  endfunction

  // Per-cycle observations of one fetch, indexed by cycles after the detect edge.
  logic       o_rv   [1:40];
  logic       o_busy [1:40];
  logic       o_oob  [1:40];
  logic       o_lerr [1:40];
  logic [7:0] o_rd   [1:40];
  logic [1:0] o_st   [1:40];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [7:0] d, output logic err);
    load_addr = a; load_data = d; load_en = 1'b1;
    tick();
    err = lerr_o;
    load_en = 1'b0;
  endtask

  task automatic drive_fetch(input logic [15:0] a, input int n, input int abort_k,
                             input int load_k, input logic [15:0] la, input logic [7:0] ld,
                             input int rst_k);
    addr = a; cs_n = 1'b0;
    if (load_k == 0) begin load_addr = la; load_data = ld; load_en = 1'b1; end
    for (int k = 1; k <= n; k++) begin
      tick();
      load_en = 1'b0; rst = 1'b0;
      o_rv[k] = rv_o; o_busy[k] = busy_o; o_oob[k] = oob_o;
      o_lerr[k] = lerr_o; o_rd[k] = rd_o; o_st[k] = st_o;
      if (k == abort_k) cs_n = 1'b1;
      if (k == load_k) begin load_addr = la; load_data = ld; load_en = 1'b1; end
      if (k == rst_k) rst = 1'b1;
    end
    cs_n = 1'b1; load_en = 1'b0; rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++; if (rd_o !== 8'h00) begin errors++; $display("FAIL reset_rdata dut%0d got %h exp 00", s, rd_o); end
      checks++; if (rv_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid dut%0d got %b exp 0", s, rv_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b exp 0", s, busy_o); end
      checks++; if (oob_o !== 1'b0) begin errors++; $display("FAIL reset_oob dut%0d got %b exp 0", s, oob_o); end
      checks++; if (lerr_o !== 1'b0) begin errors++; $display("FAIL reset_lerr dut%0d got %b exp 0", s, lerr_o); end
      checks++; if (st_o !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d got %0d exp 0", s, st_o); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_fetch();
    logic [7:0] img [5] = '{8'h07, 8'hC0, 8'h44, 8'hC1, 8'hCB};
    logic err;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 32; i++) begin
        logic [7:0] d;
        d = (i < 5) ? img[i] : 8'($urandom);
        load_word(16'(i), d, err);
        mem_m[s][i] = d;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL image_lerr dut%0d a=%0d got %b exp 0", s, i, err); end
      end
    end
    for (int s = 0; s < 3; s += 2) begin
      int w;
      sel = s; w = ws_of(s);
      drive_fetch(16'h0002, w + 6, -1, -1, 16'h0, 8'h0, -1);
      for (int k = 1; k <= w + 6; k++) begin
        checks++; if (o_rv[k] !== (k == w + 2)) begin errors++; $display("FAIL lf_rvalid dut%0d k=%0d got %b exp %b", s, k, o_rv[k], k == w + 2); end
        checks++; if (o_busy[k] !== (k <= w + 2)) begin errors++; $display("FAIL lf_busy dut%0d k=%0d got %b exp %b", s, k, o_busy[k], k <= w + 2); end
      end
      checks++; if (o_rd[w + 2] !== 8'h44) begin errors++; $display("FAIL lf_rdata dut%0d got %h exp 44", s, o_rd[w + 2]); end
      checks++; if (o_oob[w + 2] !== 1'b0) begin errors++; $display("FAIL lf_oob dut%0d got %b exp 0", s, o_oob[w + 2]); end
    end
  endtask

  task automatic test_zero_wait();
    sel = 1;
    drive_fetch(16'h0004, 5, -1, -1, 16'h0, 8'h0, -1);
    for (int k = 1; k <= 5; k++) begin
      checks++; if (o_rv[k] !== (k == 2)) begin errors++; $display("FAIL zw_rvalid k=%0d got %b exp %b", k, o_rv[k], k == 2); end
      checks++; if (o_busy[k] !== (k <= 2)) begin errors++; $display("FAIL zw_busy k=%0d got %b exp %b", k, o_busy[k], k <= 2); end
    end
    checks++; if (o_rd[2] !== 8'hCB) begin errors++; $display("FAIL zw_rdata got %h exp cb", o_rd[2]); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] fa [4] = '{16'h0040, 16'h001F, 16'h0020, 16'h1020};
    logic err;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      logic exp_oob;
      exp_oob = (fa[i] >= 16'd32);
      drive_fetch(fa[i], 5, -1, -1, 16'h0, 8'h0, -1);
      checks++; if (o_rv[3] !== 1'b1) begin errors++; $display("FAIL oob_rvalid a=%h got %b exp 1", fa[i], o_rv[3]); end
      checks++; if (o_oob[3] !== exp_oob) begin errors++; $display("FAIL oob_flag a=%h got %b exp %b", fa[i], o_oob[3], exp_oob); end
      checks++; if (o_rd[3] !== model_read(0, fa[i])) begin errors++; $display("FAIL oob_rdata a=%h got %h exp %h", fa[i], o_rd[3], model_read(0, fa[i])); end
      checks++; if (o_oob[4] !== 1'b0) begin errors++; $display("FAIL oob_pulse a=%h got %b exp 0", fa[i], o_oob[4]); end
    end
    load_word(16'h0020, 8'h5A, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_load20 got %b exp 1", err); end
    load_word(16'h1003, 8'h5A, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_load1003 got %b exp 1", err); end
    tick();
    drive_fetch(16'h0003, 5, -1, -1, 16'h0, 8'h0, -1);
    checks++; if (o_rd[3] !== 8'hC1) begin errors++; $display("FAIL oob_noalias got %h exp c1", o_rd[3]); end
    drive_fetch(16'h0000, 5, -1, -1, 16'h0, 8'h0, -1);
    checks++; if (o_rd[3] !== 8'h07) begin errors++; $display("FAIL oob_noalias0 got %h exp 07", o_rd[3]); end
  endtask

  task automatic test_abort();
    sel = 2;
    drive_fetch(16'h0001, 10, 2, -1, 16'h0, 8'h0, -1);
    for (int k = 1; k <= 10; k++) begin
      checks++; if (o_rv[k] !== 1'b0) begin errors++; $display("FAIL ab_rvalid k=%0d got %b exp 0", k, o_rv[k]); end
      checks++; if (o_rd[k] !== 8'h44) begin errors++; $display("FAIL ab_rdata k=%0d got %h exp 44", k, o_rd[k]); end
      checks++; if (o_busy[k] !== (k <= 2)) begin errors++; $display("FAIL ab_busy k=%0d got %b exp %b", k, o_busy[k], k <= 2); end
    end
    checks++; if (o_st[3] !== 2'd0) begin errors++; $display("FAIL ab_state got %0d exp 0", o_st[3]); end
    drive_fetch(16'h0001, 8, -1, -1, 16'h0, 8'h0, -1);
    checks++; if (o_rv[6] !== 1'b1) begin errors++; $display("FAIL ab_refetch_rv got %b exp 1", o_rv[6]); end
    checks++; if (o_rd[6] !== 8'hC0) begin errors++; $display("FAIL ab_refetch_rd got %h exp c0", o_rd[6]); end
  endtask

  task automatic test_load_during_fetch();
    sel = 0;
    drive_fetch(16'h0003, 5, -1, 1, 16'h0003, 8'h3E, -1);
    for (int k = 1; k <= 5; k++) begin
      checks++; if (o_lerr[k] !== (k == 2)) begin errors++; $display("FAIL ldf_lerr k=%0d got %b exp %b", k, o_lerr[k], k == 2); end
    end
    checks++; if (o_rd[3] !== model_read(0, 16'h0003)) begin errors++; $display("FAIL ldf_rdata got %h exp %h", o_rd[3], model_read(0, 16'h0003)); end
    drive_fetch(16'h0002, 5, -1, 0, 16'h0004, 8'h99, -1);
    checks++; if (o_lerr[1] !== 1'b1) begin errors++; $display("FAIL sim_lerr got %b exp 1", o_lerr[1]); end
    checks++; if (o_rv[3] !== 1'b1) begin errors++; $display("FAIL sim_rvalid got %b exp 1", o_rv[3]); end
    checks++; if (o_rd[3] !== 8'h44) begin errors++; $display("FAIL sim_rdata got %h exp 44", o_rd[3]); end
    drive_fetch(16'h0004, 5, -1, -1, 16'h0, 8'h0, -1);
    checks++; if (o_rd[3] !== 8'hCB) begin errors++; $display("FAIL sim_old_word got %h exp cb", o_rd[3]); end
    drive_fetch(16'h0003, 5, -1, -1, 16'h0, 8'h0, -1);
    checks++; if (o_rd[3] !== 8'hC1) begin errors++; $display("FAIL ldf_old_word got %h exp c1", o_rd[3]); end
  endtask

  task automatic test_reset_mid_fetch();
    sel = 2;
    drive_fetch(16'h0000, 10, 1, -1, 16'h0, 8'h0, 1);
    checks++; if (o_busy[1] !== 1'b1) begin errors++; $display("FAIL rmf_busy1 got %b exp 1", o_busy[1]); end
    for (int k = 2; k <= 10; k++) begin
      checks++; if (o_busy[k] !== 1'b0) begin errors++; $display("FAIL rmf_busy k=%0d got %b exp 0", k, o_busy[k]); end
      checks++; if (o_rd[k] !== 8'h00) begin errors++; $display("FAIL rmf_rdata k=%0d got %h exp 00", k, o_rd[k]); end
      checks++; if (o_rv[k] !== 1'b0) begin errors++; $display("FAIL rmf_rvalid k=%0d got %b exp 0", k, o_rv[k]); end
    end
    checks++; if (o_st[2] !== 2'd0) begin errors++; $display("FAIL rmf_state got %0d exp 0", o_st[2]); end
    drive_fetch(16'h0002, 8, -1, -1, 16'h0, 8'h0, -1);
    checks++; if (o_rd[6] !== 8'h44) begin errors++; $display("FAIL rmf_mem_kept got %h exp 44", o_rd[6]); end
  endtask

  task automatic test_back_to_back();
    logic err;
    int got, idx, n_ticks;
    logic rise;
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      load_word(16'(i), d, err);
      mem_m[0][i] = d;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_lerr a=%0d got %b exp 0", i, err); end
    end
    for (int i = 0; i < 20; i++) exp_q.push_back(mem_m[0][i]);
    tick();
    got = 0; idx = 0; n_ticks = 0; rise = 1'b0;
    addr = 16'h0000; cs_n = 1'b0;
    while (got < 20 && n_ticks < 400) begin
      tick();
      n_ticks++;
      if (rise) begin
        rise = 1'b0;
        cs_n = 1'b0; addr = 16'(idx);
      end else if (rv_o) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++; if (rd_o !== e) begin errors++; $display("FAIL b2b_rdata n=%0d got %h exp %h", got, rd_o, e); end
        got++; idx++;
        cs_n = 1'b1; rise = 1'b1;
      end
    end
    cs_n = 1'b1;
    tick(); tick();
    checks++; if (got !== 20) begin errors++; $display("FAIL b2b_count got %0d exp 20", got); end
    checks++; if (n_ticks !== 79) begin errors++; $display("FAIL b2b_cycles got %0d exp 79", n_ticks); end
  endtask

  task automatic test_random();
    logic err;
    for (int it = 0; it < 40; it++) begin
      int s, w;
      logic [15:0] fa;
      s = $urandom_range(0, 2); sel = s; w = ws_of(s);
      if ($urandom_range(0, 1) == 1) begin
        logic [15:0] la;
        logic [7:0]  ld;
        la = 16'($urandom_range(0, 40)); ld = 8'($urandom);
        load_word(la, ld, err);
        checks++; if (err !== (la >= 16'd32)) begin errors++; $display("FAIL rnd_lerr a=%h got %b exp %b", la, err, la >= 16'd32); end
        if (la < 16'd32) mem_m[s][la[4:0]] = ld;
        tick();
      end
      fa = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 40));
      drive_fetch(fa, w + 4, -1, -1, 16'h0, 8'h0, -1);
      for (int k = 1; k <= w + 4; k++) begin
        checks++; if (o_rv[k] !== (k == w + 2)) begin errors++; $display("FAIL rnd_rvalid dut%0d a=%h k=%0d got %b exp %b", s, fa, k, o_rv[k], k == w + 2); end
      end
      checks++; if (o_rd[w + 2] !== model_read(s, fa)) begin errors++; $display("FAIL rnd_rdata dut%0d a=%h got %h exp %h", s, fa, o_rd[w + 2], model_read(s, fa)); end
      checks++; if (o_oob[w + 2] !== (fa >= 16'd32)) begin errors++; $display("FAIL rnd_oob dut%0d a=%h got %b exp %b", s, fa, o_oob[w + 2], fa >= 16'd32); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs_n = 1'b1; addr = '0; sel = 0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    tick();
    test_reset();
    test_load_fetch();
    test_zero_wait();
    test_out_of_range();
    test_abort();
    test_load_during_fetch();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
